cell_truth_seq: RTL and testbench

//  Self-checking truth-table sequencer for N-input single-output standard cells (NOR3_X4 etc.).

---
 rtl/cell_truth_seq.sv | 144 ++++++++++++++
 tb/tb_cell_truth_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_truth_seq.sv
// cell_truth_seq
//   Clocked truth-table sequencer for an N-input, single-output standard cell.
//   It steps dut_in through every vector 0 .. 2**N_IN-1 in ascending order.
//   Each vector is held for SETTLE+1 cycles, and dut_out is sampled on the last one.
//   Each sample is compared against the packed EXPECT table, where bit i is the
//   expected output for vector i. The block counts mismatches and reports pass/fail.
//
// Parameters
//   N_IN    number of cell inputs (1..6)
//   EXPECT  expected output table, width 2**N_IN (default: NOR-N)
//   SETTLE  extra hold cycles per vector before sampling (0..15)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   begin a run (accepted only when idle)
//   dut_out    in   output of the cell under test
//   dut_in     out  vector driven onto the cell inputs (MSB = A1)
//   busy       out  run in progress
//   done       out  one-cycle pulse at the end of a run
//   pass       out  last completed run had zero mismatches
//   err_count  out  mismatch count of current/last run
//   fail_vec   out  first mismatching vector (0 if none)
//   fail_seen  out  at least one mismatch in current/last run
//
// Build option
//   CELL_SEQ_STOP_ON_FAIL_EN : when defined, the first mismatch ends the run.
module cell_truth_seq #(
    parameter int                    N_IN   = 3,
    parameter logic [2**N_IN-1:0]    EXPECT = {{(2**N_IN-1){1'b0}}, 1'b1},
    parameter int                    SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dut_out,
    output logic [N_IN-1:0]   dut_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   fail_vec,
    output logic              fail_seen
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [N_IN-1:0]   idx_q;
    logic [3:0]        cnt_q;
    logic [N_IN:0]     err_q;
    logic [N_IN-1:0]   fvec_q;
    logic              fseen_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;

    logic              mismatch;
    logic [N_IN:0]     err_d;
    logic              last_d;

    // An X/Z on dut_out must count as a mismatch, so the comparison is a case inequality.
    always_comb begin
        mismatch = (dut_out !== EXPECT[idx_q]);
        err_d    = err_q + {{N_IN{1'b0}}, mismatch};
`ifdef CELL_SEQ_STOP_ON_FAIL_EN
        last_d   = (idx_q == '1) || mismatch;
`else
        last_d   = (idx_q == '1);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fvec_q  <= '0;
            fseen_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        err_q   <= '0;
                        fvec_q  <= '0;
                        fseen_q <= 1'b0;
                        pass_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (cnt_q != SETTLE_C) begin
                        cnt_q <= cnt_q + 4'd1;
                    end else begin
                        err_q <= err_d;
                        if (mismatch && !fseen_q) begin
                            fvec_q  <= idx_q;
                            fseen_q <= 1'b1;
                        end
                        // pass uses err_d so that a mismatch on the final sample is included.
                        if (last_d) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == '0);
                        end else begin
                            idx_q <= idx_q + N_IN'(1);
                            cnt_q <= '0;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign dut_in    = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fvec_q;
    assign fail_seen = fseen_q;

endmodule

// File: tb/tb_cell_truth_seq.sv
// tb_cell_truth_seq
//   Randomised scoreboard bench for cell_truth_seq. The bench models the cell under test
//   with a per-vector response table. For SETTLE cycles after dut_in changes, the model
//   drives random noise on dut_out, so sampling too early is exposed. Each accepted start
//   pushes a predicted result. That prediction is derived from the response table and
//   the expected table. A monitor pops the prediction on every done pulse and compares it.
module tb_cell_truth_seq;

    localparam int N_IN   = 3;
    localparam int SETTLE = 2;
    localparam int NV     = 1 << N_IN;
    localparam int RUNLEN = NV * (SETTLE + 1);
    localparam logic [NV-1:0] EXPECT = 8'h01;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              dut_out;
    logic [N_IN-1:0]   dut_in;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_IN:0]     err_count;
    logic [N_IN-1:0]   fail_vec;
    logic              fail_seen;

    cell_truth_seq #(
        .N_IN   (N_IN),
        .EXPECT (EXPECT),
        .SETTLE (SETTLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dut_out   (dut_out),
        .dut_in    (dut_in),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_vec  (fail_vec),
        .fail_seen (fail_seen)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned err;
        int unsigned fv;
        int unsigned fs;
        int unsigned ps;
        int unsigned done_edge;
        int unsigned last_vec;
    } exp_t;

    exp_t            sbq[$];
    logic            resp [NV];
    logic [NV-1:0]   exp_tab = EXPECT;
    int unsigned     edge_no = 0;
    int              checks = 0;
    int              errors = 0;

    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: walk the whole table and reason about the run as a whole.
    function automatic exp_t model(input int unsigned accept_edge);
        exp_t e;
        e.err = 0; e.fv = 0; e.fs = 0;
        for (int v = 0; v < NV; v++) begin
            if (resp[v] !== exp_tab[v]) begin
                if (e.fs == 0) begin
                    e.fv = v;
                    e.fs = 1;
                end
                e.err++;
            end
        end
        e.done_edge = accept_edge + RUNLEN;
        e.last_vec  = NV - 1;
`ifdef CELL_SEQ_STOP_ON_FAIL_EN
        if (e.fs != 0) begin
            e.err       = 1;
            e.done_edge = accept_edge + (e.fv + 1) * (SETTLE + 1);
            e.last_vec  = e.fv;
        end
`endif
        e.ps = (e.err == 0) ? 1 : 0;
        return e;
    endfunction

    // Cell model: output is valid only once the input has been stable for SETTLE cycles.
    initial begin
        logic [N_IN-1:0] last_in;
        int unsigned     age;
        last_in = '0;
        age     = 100;
        dut_out = 1'b0;
        forever begin
            @(negedge clk);
            if (dut_in !== last_in) age = 0;
            else if (age < 100) age++;
            last_in = dut_in;
            if (age >= SETTLE) dut_out = resp[dut_in];
            else dut_out = 1'($urandom_range(0, 1));
        end
    end

    // Monitor
    initial begin
        exp_t e;
        bit   prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_done) chk("done_pulse_width", {31'd0, done}, 32'd0);
            prev_done = 1'b0;
            if (!rst && done === 1'b1) begin
                prev_done = 1'b1;
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("err_count", 32'(err_count), e.err);
                    chk("fail_vec",  32'(fail_vec),  e.fv);
                    chk("fail_seen", {31'd0, fail_seen}, e.fs);
                    chk("pass",      {31'd0, pass},  e.ps);
                    chk("busy_at_done", {31'd0, busy}, 32'd0);
                    chk("last_vec",  32'(dut_in),    e.last_vec);
                    chk("done_edge", edge_no,        e.done_edge);
                end
            end
        end
    end

    task automatic wait_done(input string name);
        int unsigned n;
        n = 0;
        while (done !== 1'b1 && n < 2 * RUNLEN + 20) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            chk({name, "_timeout"}, 32'd1, 32'd0);
            sbq.delete();
        end
    endtask

    task automatic run(input string name, input bit poke);
        int unsigned a;
        @(negedge clk);
        start = 1'b1;
        a = edge_no + 1;
        sbq.push_back(model(a));
        @(negedge clk);
        start = 1'b0;
        if (poke) begin
            // Pulses land on edges 5 and 20 of the run (accept edge = edge 1).
            while (edge_no < a + 3) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            while (edge_no < a + 18) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(name);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_dut_in"},    32'(dut_in),    32'd0);
        chk({name, "_busy"},      {31'd0, busy},  32'd0);
        chk({name, "_done"},      {31'd0, done},  32'd0);
        chk({name, "_pass"},      {31'd0, pass},  32'd0);
        chk({name, "_err_count"}, 32'(err_count), 32'd0);
        chk({name, "_fail_vec"},  32'(fail_vec),  32'd0);
        chk({name, "_fail_seen"}, {31'd0, fail_seen}, 32'd0);
    endtask

    task automatic set_correct();
        for (int v = 0; v < NV; v++) resp[v] = exp_tab[v];
    endtask

    initial begin
        int unsigned a;
        int unsigned dn;
        rst   = 1'b1;
        start = 1'b0;
        set_correct();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Correct cell
        run("correct", 1'b0);

        // Stuck-at-0
        for (int v = 0; v < NV; v++) resp[v] = 1'b0;
        run("stuck0", 1'b0);

        // Inverted output
        for (int v = 0; v < NV; v++) resp[v] = ~exp_tab[v];
        run("inverted", 1'b0);

        // Reset on edge 13 of a run abandons it
        set_correct();
        @(negedge clk);
        start = 1'b1;
        a = edge_no + 1;
        sbq.push_back(model(a));
        @(negedge clk);
        start = 1'b0;
        while (edge_no < a + 11) @(negedge clk);
        rst = 1'b1;
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        check_zero("midrun_rst");
        dn = 0;
        for (int i = 0; i < RUNLEN + 5; i++) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        chk("no_done_after_rst", dn, 32'd0);
        run("after_rst", 1'b0);

        // start re-pulsed while busy
        run("repoke", 1'b1);

        // X on vector 6 only
        set_correct();
        resp[6] = 1'bx;
        run("x_vec6", 1'b0);

        // Random tables with sparse faults
        for (int r = 0; r < 8; r++) begin
            for (int v = 0; v < NV; v++)
                resp[v] = exp_tab[v] ^ ($urandom_range(0, 3) == 0);
            run("random", 1'b0);
        end

        // start held high: the next run is accepted on the first idle edge after done
        for (int v = 0; v < NV; v++)
            resp[v] = exp_tab[v] ^ ($urandom_range(0, 2) == 0);
        @(negedge clk);
        start = 1'b1;
        sbq.push_back(model(edge_no + 1));
        wait_done("held_first");
        sbq.push_back(model(edge_no + 2));
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done("held_second");
        repeat (3) @(negedge clk);

        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
